fetch_unit: RTL and testbench

Instruction-fetch stage of the DLX pipeline: owns the program counter, issues word requests to instruction memory, and loads the IF/ID pipeline register. It consumes the redirect (`take_branch`, `branch_target`) produced by the ID-stage jump/branch resolver and squashes the wrong-path instruction. It honours the hazard unit's `stall` and never loses or duplicates an instruction across stalls, waits or redirects.

---
 rtl/dlx_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_hold_buf.sv | 50 +++++
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: word type, reset/NOP constants and the fetch FSM states.
// Imported by the fetch stage, the branch resolver and the decoder.
package dlx_pkg;

  typedef logic [31:0] word_t;

  localparam word_t DLX_NOP      = 32'h0000_0000;
  localparam word_t DLX_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // Instruction addresses are always word aligned.
  function automatic word_t word_align(input word_t a);
    return a & ~32'd3;
  endfunction

  function automatic word_t next_pc(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect/stall inputs, instruction-memory handshake and IF/ID outputs.
// The master modport is the fetch unit; the slave side is memory plus the ID stage.
interface fetch_unit_if;
  import dlx_pkg::*;

  logic  stall;
  logic  take_branch;
  word_t branch_target;

  logic  imem_req;
  word_t imem_addr;
  word_t imem_rdata;
  logic  imem_ready;

  logic  ifid_valid;
  word_t ifid_instr;
  word_t ifid_pc;

  modport master (
    input  stall, take_branch, branch_target, imem_rdata, imem_ready,
    output imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc
  );

  modport slave (
    output stall, take_branch, branch_target, imem_rdata, imem_ready,
    input  imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry buffer for an instruction fetched while the pipeline was stalled.
// Clear wins over load so a redirect always discards the parked word.
module fetch_hold_buf
  import dlx_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  clear,
  input  word_t load_instr,
  input  word_t load_pc,
  output logic  valid,
  output word_t instr,
  output word_t pc
);

  logic  valid_q, valid_d;
  word_t instr_q, instr_d;
  word_t pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// DLX instruction-fetch stage: owns the PC, drives instruction memory and loads IF/ID.
// Handles hazard stalls, variable memory latency and ID-stage redirects without loss or duplication.
module fetch_unit
  import dlx_pkg::*;
#(
  parameter word_t RESET_PC  = DLX_RESET_PC,
  parameter word_t NOP_INSTR = DLX_NOP
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  logic         ifid_valid_q, ifid_valid_d;
  word_t        ifid_instr_q, ifid_instr_d;
  word_t        ifid_pc_q, ifid_pc_d;
  word_t        drain_addr_q, drain_addr_d;

  logic         hold_load, hold_clear, hold_valid;
  word_t        hold_instr, hold_pc;

  logic         imem_req;
  word_t        imem_addr;
  logic         redirect;
  word_t        target;

  // A branch seen under stall is dropped; the resolver re-asserts it later.
  assign redirect = bus.take_branch & ~bus.stall;
  assign target   = word_align(bus.branch_target);

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (hold_load),
    .clear      (hold_clear),
    .load_instr (bus.imem_rdata),
    .load_pc    (pc_q),
    .valid      (hold_valid),
    .instr      (hold_instr),
    .pc         (hold_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (redirect) begin
          state_d = bus.imem_ready ? FETCH : DRAIN;
        end else if (bus.imem_ready && bus.stall) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (bus.imem_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // DRAIN keeps presenting the abandoned address until memory completes it.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      FETCH: imem_req = 1'b1;
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    drain_addr_d = drain_addr_q;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          hold_clear   = 1'b1;
          if (!bus.imem_ready) begin
            drain_addr_d = pc_q;
          end
        end else if (bus.imem_ready) begin
          pc_d = next_pc(pc_q);
          if (bus.stall) begin
            hold_load = 1'b1;
          end else begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = bus.imem_rdata;
            ifid_pc_d    = pc_q;
          end
        end else if (!bus.stall) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
      end
      HOLD: begin
        if (redirect) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          hold_clear   = 1'b1;
        end else if (!bus.stall) begin
          ifid_valid_d = hold_valid;
          ifid_instr_d = hold_valid ? hold_instr : NOP_INSTR;
          ifid_pc_d    = hold_pc;
        end
      end
      default: ;
    endcase
    if (redirect) begin
      pc_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      drain_addr_q <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.imem_addr  = imem_addr;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc    = ifid_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit; the random phase checks the delivered
// instruction stream against a program-order model (next PC, redirect target, stall freeze).
module tb_fetch_unit;
  import dlx_pkg::*;

  localparam word_t RESET_PC = 32'h0000_0000;
  localparam word_t NOP      = 32'h5400_0000;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t mem_word(input word_t a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle just after the rising edge.
  task automatic applyStimulus(input logic st, input logic br, input word_t tgt,
                               input logic rdy, input logic rst);
    @(negedge clk);
    reset             = rst;
    bus.stall         = st;
    bus.take_branch   = br;
    bus.branch_target = tgt;
    bus.imem_ready    = rdy;
    bus.imem_rdata    = rdy ? mem_word(bus.imem_addr) : 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    word_t exp_pc, pre_instr, pre_pc, pre_addr, tgt;
    logic  pre_valid, pre_req, st, br, rdy;
    int    delivered;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.take_branch = 1'b0;
    bus.branch_target = '0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;

    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_req",   bus.imem_req,   0);
    checkOutput("rst_addr",  bus.imem_addr,  RESET_PC);
    checkOutput("rst_valid", bus.ifid_valid, 0);
    checkOutput("rst_instr", bus.ifid_instr, NOP);
    checkOutput("rst_pc",    bus.ifid_pc,    0);

    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("boot_req",   bus.imem_req,   1);
    checkOutput("boot_addr",  bus.imem_addr,  RESET_PC);
    checkOutput("boot_valid", bus.ifid_valid, 0);

    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("seq0_pc",    bus.ifid_pc,    32'h0);
    checkOutput("seq0_instr", bus.ifid_instr, mem_word(32'h0));
    checkOutput("seq0_valid", bus.ifid_valid, 1);
    checkOutput("seq0_addr",  bus.imem_addr,  32'h4);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("seq4_pc",    bus.ifid_pc,    32'h4);
    checkOutput("seq4_addr",  bus.imem_addr,  32'h8);

    applyStimulus(0, 1, 32'h100, 1, 0);
    checkOutput("br_valid", bus.ifid_valid, 0);
    checkOutput("br_instr", bus.ifid_instr, NOP);
    checkOutput("br_addr",  bus.imem_addr,  32'h100);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("br_tgt_pc",    bus.ifid_pc,    32'h100);
    checkOutput("br_tgt_instr", bus.ifid_instr, mem_word(32'h100));
    checkOutput("br_next_addr", bus.imem_addr,  32'h104);

    applyStimulus(0, 1, 32'h8, 1, 0);
    checkOutput("br8_addr", bus.imem_addr, 32'h8);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("br8_pc", bus.ifid_pc, 32'h8);

    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("stall1_req",   bus.imem_req,   0);
    checkOutput("stall1_pc",    bus.ifid_pc,    32'h8);
    checkOutput("stall1_valid", bus.ifid_valid, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("stall2_req", bus.imem_req, 0);
    checkOutput("stall2_pc",  bus.ifid_pc,  32'h8);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("stall3_req",   bus.imem_req,   0);
    checkOutput("stall3_instr", bus.ifid_instr, mem_word(32'h8));
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("unstall_pc",    bus.ifid_pc,    32'hC);
    checkOutput("unstall_instr", bus.ifid_instr, mem_word(32'hC));
    checkOutput("unstall_valid", bus.ifid_valid, 1);
    checkOutput("unstall_req",   bus.imem_req,   1);
    checkOutput("unstall_addr",  bus.imem_addr,  32'h10);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("after_stall_pc",   bus.ifid_pc,   32'h10);
    checkOutput("after_stall_addr", bus.imem_addr, 32'h14);

    applyStimulus(0, 1, 32'h200, 0, 0);
    checkOutput("drain1_req",   bus.imem_req,   1);
    checkOutput("drain1_addr",  bus.imem_addr,  32'h14);
    checkOutput("drain1_valid", bus.ifid_valid, 0);
    checkOutput("drain1_instr", bus.ifid_instr, NOP);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drain2_addr",  bus.imem_addr,  32'h14);
    checkOutput("drain2_valid", bus.ifid_valid, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("drain3_addr",  bus.imem_addr,  32'h200);
    checkOutput("drain3_valid", bus.ifid_valid, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("drain_tgt_pc",    bus.ifid_pc,    32'h200);
    checkOutput("drain_tgt_instr", bus.ifid_instr, mem_word(32'h200));
    checkOutput("drain_tgt_addr",  bus.imem_addr,  32'h204);

    applyStimulus(1, 1, 32'h300, 0, 0);
    checkOutput("brstall_addr",  bus.imem_addr,  32'h204);
    checkOutput("brstall_pc",    bus.ifid_pc,    32'h200);
    checkOutput("brstall_valid", bus.ifid_valid, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("brstall_next_pc",   bus.ifid_pc,   32'h204);
    checkOutput("brstall_next_addr", bus.imem_addr, 32'h208);

    applyStimulus(0, 1, 32'h103, 1, 0);
    checkOutput("align_addr", bus.imem_addr, 32'h100);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("align_pc", bus.ifid_pc, 32'h100);

    applyStimulus(0, 1, 32'hFFFF_FFFC, 1, 0);
    checkOutput("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("wrap_pc",    bus.ifid_pc,   32'hFFFF_FFFC);
    checkOutput("wrap_addr1", bus.imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("wrap_pc0", bus.ifid_pc, 32'h0);

    applyStimulus(0, 1, 32'h40, 0, 0);
    checkOutput("rdrain_req",  bus.imem_req,  1);
    checkOutput("rdrain_addr", bus.imem_addr, 32'h4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rdrain_rst_req",   bus.imem_req,   0);
    checkOutput("rdrain_rst_valid", bus.ifid_valid, 0);
    checkOutput("rdrain_rst_instr", bus.ifid_instr, NOP);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rdrain_boot_req",  bus.imem_req,  1);
    checkOutput("rdrain_boot_addr", bus.imem_addr, RESET_PC);

    exp_pc    = RESET_PC;
    delivered = 0;
    for (int n = 0; n < 600; n++) begin
      pre_valid = bus.ifid_valid;
      pre_instr = bus.ifid_instr;
      pre_pc    = bus.ifid_pc;
      pre_req   = bus.imem_req;
      pre_addr  = bus.imem_addr;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      rdy = pre_req & ($urandom_range(0, 1) == 1);
      applyStimulus(st, br, tgt, rdy, 0);

      if (pre_req && !rdy && bus.imem_req)
        checkOutput("rnd_addr_stable", bus.imem_addr, pre_addr);
      if (bus.imem_req)
        checkOutput("rnd_addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);

      if (st) begin
        checkOutput("rnd_stall_valid", bus.ifid_valid, pre_valid);
        checkOutput("rnd_stall_instr", bus.ifid_instr, pre_instr);
        checkOutput("rnd_stall_pc",    bus.ifid_pc,    pre_pc);
      end else if (br) begin
        checkOutput("rnd_squash_valid", bus.ifid_valid, 0);
        checkOutput("rnd_squash_instr", bus.ifid_instr, NOP);
        exp_pc = {tgt[31:2], 2'b00};
      end else if (bus.ifid_valid) begin
        checkOutput("rnd_stream_pc",    bus.ifid_pc,    exp_pc);
        checkOutput("rnd_stream_instr", bus.ifid_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else begin
        checkOutput("rnd_bubble_instr", bus.ifid_instr, NOP);
      end
    end
    checkOutput("rnd_progress", (delivered >= 40) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
